// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg : shared types and constants for the writeback arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } wb_arb_state_e;

  localparam int STATS_CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin picker, search starts at ptr_i
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req_i[i] && (i == ((int'(ptr_i) + k) % N))) begin
          gnt_o[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// regfile_wb_arbiter : clears x1..xN after reset, then arbitrates writebacks
// Optional WB_ARB_STATS_EN adds per-requester saturating grant counters.
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_wb_arbiter
  import riscv_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          flush_i,
  output logic                          wr_enable_o,
  output logic [ADDR_WIDTH-1:0]         wr_addr_o,
  output logic [DATA_WIDTH-1:0]         wr_data_o,
  output logic                          init_done_o
`ifdef WB_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_CNT_W-1:0] grant_cnt_o
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  wb_arb_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_addr_q, init_addr_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    init_done_q, init_done_d;

  logic [NUM_REQ-1:0]      arb_gnt;
  logic [NUM_REQ-1:0]      gnt;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [PTR_W-1:0]        ptr_next;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    gnt = '0;
    if (state_q == RUN && !flush_i) begin
      gnt = arb_gnt;
    end
  end

  assign req_ready_o = gnt;

  // Mux the winner's payload and the pointer slot just past it
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    ptr_next = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        ptr_next = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    ptr_d       = ptr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    init_done_d = init_done_q;
    case (state_q)
      INIT: begin
        wr_en_d     = 1'b1;
        wr_addr_d   = init_addr_q;
        wr_data_d   = '0;
        init_addr_d = init_addr_q + ADDR_WIDTH'(1);
        if (init_addr_q == '1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        init_done_d = 1'b1;
        if (|gnt) begin
          ptr_d = ptr_next;
          // x0 is hardwired zero: accept the handshake but suppress the write
          if (sel_addr != '0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= INIT;
      init_addr_q <= ADDR_WIDTH'(1);
      ptr_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      ptr_q       <= ptr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      init_done_q <= init_done_d;
    end
  end

  assign wr_enable_o = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign init_done_o = init_done_q;

`ifdef WB_ARB_STATS_EN
  logic [STATS_CNT_W-1:0] cnt_q [NUM_REQ];
  logic [STATS_CNT_W-1:0] cnt_d [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (gnt[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + STATS_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rst_ni) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt_out
    assign grant_cnt_o[gi*STATS_CNT_W +: STATS_CNT_W] = cnt_q[gi];
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// tb_regfile_wb_arbiter : directed bench with a cycle-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

  localparam int NR = 3;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int LAST = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic [NR-1:0] valid = '0;
  logic [AW-1:0] ta [NR];
  logic [DW-1:0] td [NR];
  logic          flush = 1'b0;
  logic [NR-1:0] ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          init_done;
`ifdef WB_ARB_STATS_EN
  logic [NR*16-1:0] grant_cnt;
`endif

  wire [NR*AW-1:0] addr_bus = {ta[2], ta[1], ta[0]};
  wire [NR*DW-1:0] data_bus = {td[2], td[1], td[0]};

  regfile_wb_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (valid),
    .req_addr_i  (addr_bus),
    .req_data_i  (data_bus),
    .req_ready_o (ready),
    .flush_i     (flush),
    .wr_enable_o (wr_en),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .init_done_o (init_done)
`ifdef WB_ARB_STATS_EN
    ,
    .grant_cnt_o (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_inits = 0;   // clear writes already registered
  int         m_ptr = 0;
  bit         m_en = 0;
  bit         m_known = 1;
  bit         m_done = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;

  function automatic int pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++) begin
      if (v[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] exp_ready();
    int g;
    logic [NR-1:0] r;
    r = '0;
    if (m_inits == LAST && !flush) begin
      g = pick(valid, m_ptr);
      if (g >= 0) r[g] = 1'b1;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    int g;
    if (!rst_ni) begin
      m_inits = 0; m_ptr = 0; m_en = 0; m_known = 1; m_done = 0;
      m_addr = '0; m_data = '0;
    end else if (m_inits < LAST) begin
      m_inits++;
      m_en = 1; m_known = 1; m_addr = AW'(m_inits); m_data = '0;
    end else begin
      m_done = 1;
      g = flush ? -1 : pick(valid, m_ptr);
      m_en = 0;
      if (g >= 0) begin
        m_ptr = (g + 1) % NR;
        if (ta[g] != '0) begin
          m_en = 1; m_known = 1; m_addr = ta[g]; m_data = td[g];
        end else begin
          m_known = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_ready", ready, exp_ready());
      check("model_wr_en", wr_en, m_en);
      check("model_init_done", init_done, m_done);
      if (m_en || m_known) begin
        check("model_wr_addr", wr_addr, m_addr);
        check("model_wr_data", wr_data, m_data);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_init(input int stop_at);
    int got = 0;
    for (int cyc = 0; cyc < 40 && got < stop_at; cyc++) begin
      @(negedge clk);
      check("init_ready", ready, '0);
      check("init_done_low", init_done, 1'b0);
      if (wr_en) begin
        check("init_addr", wr_addr, 64'(got + 1));
        check("init_data", wr_data, '0);
        got++;
      end else if (got > 0) begin
        check("init_gap", wr_en, 1'b1);
      end
    end
    check("init_write_count", 64'(got), 64'(stop_at));
    if (stop_at == LAST) begin
      @(negedge clk);
      check("init_done_set", init_done, 1'b1);
      check("init_done_no_wr", wr_en, 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      ta[i] = '0;
      td[i] = '0;
    end
    step();
    chk_en = 1'b1;
    step();
    @(negedge clk);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_wr_addr", wr_addr, '0);
    check("rst_wr_data", wr_data, '0);
    check("rst_init_done", init_done, 1'b0);
    step();
    rst_ni = 1'b1;
    run_init(LAST);

    // round-robin over three continuous requesters
    step();
    valid = 3'b111;
    ta[0] = 5'd3; ta[1] = 5'd4; ta[2] = 5'd5;
    td[0] = 32'h33; td[1] = 32'h44; td[2] = 32'h55;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rr_ready", ready, 64'(1 << (i % 3)));
      if (i > 0) begin
        check("rr_wr_en", wr_en, 1'b1);
        check("rr_wr_addr", wr_addr, 64'(3 + ((i - 1) % 3)));
      end
    end
    step();
    valid = '0;
    @(negedge clk);
    check("rr_last_addr", wr_addr, 64'd5);
    check("rr_last_data", wr_data, 64'h55);

    // single requester, x7
    step();
    valid = 3'b010; ta[1] = 5'd7; td[1] = 32'hCAFE_BABE;
    @(negedge clk);
    check("x7_ready", ready, 3'b010);
    step();
    valid = '0;
    @(negedge clk);
    check("x7_wr_en", wr_en, 1'b1);
    check("x7_wr_addr", wr_addr, 64'd7);
    check("x7_wr_data", wr_data, 64'hCAFE_BABE);
    @(negedge clk);
    check("x7_idle_en", wr_en, 1'b0);
    check("x7_hold_addr", wr_addr, 64'd7);

    // write to x0 is accepted but suppressed
    step();
    valid = 3'b001; ta[0] = 5'd0; td[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    check("x0_ready", ready, 3'b001);
    step();
    valid = '0;
    @(negedge clk);
    check("x0_wr_en", wr_en, 1'b0);
`ifdef WB_ARB_STATS_EN
    check("x0_grant_cnt0", grant_cnt[15:0], 64'd3);
`endif

    // move ptr to 0, then flush with a write in flight
    step();
    valid = 3'b100; ta[2] = 5'd9; td[2] = 32'h1234_5678;
    @(negedge clk);
    check("p2_ready", ready, 3'b100);
    step();
    valid = 3'b101; flush = 1'b1; ta[0] = 5'd1; td[0] = 32'h0A0A;
    @(negedge clk);
    check("flush1_ready", ready, '0);
    check("flush1_inflight_en", wr_en, 1'b1);
    check("flush1_inflight_addr", wr_addr, 64'd9);
    @(negedge clk);
    check("flush2_ready", ready, '0);
    check("flush2_wr_en", wr_en, 1'b0);
    step();
    flush = 1'b0;
    @(negedge clk);
    check("post_flush_ready0", ready, 3'b001);
    step();
    valid = 3'b100;
    @(negedge clk);
    check("post_flush_ready2", ready, 3'b100);
    check("post_flush_wr_addr", wr_addr, 64'd1);
    check("post_flush_wr_data", wr_data, 64'h0A0A);
    step();
    valid = '0;
    @(negedge clk);
    check("post_flush_wr2_addr", wr_addr, 64'd9);

    // reset in RUN drops the in-flight grant
    step();
    valid = 3'b010; ta[1] = 5'd12; td[1] = 32'hBAD0;
    rst_ni = 1'b0;
    @(negedge clk);
    step();
    rst_ni = 1'b1; valid = '0;
    @(negedge clk);
    check("run_rst_wr_en", wr_en, 1'b0);
    check("run_rst_wr_addr", wr_addr, '0);
    check("run_rst_init_done", init_done, 1'b0);

    // reset pulse mid-clear restarts from x1
    run_init(10);
    step();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    run_init(LAST);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
